// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode encodings and the issue-slot control struct for the ALU issue stage.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int REG_AW  = 5;
    localparam int SHAMT_W = 5;

    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_AND = 4'd2;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd3;
    localparam logic [SEL_W-1:0] OP_SLT = 4'd4;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd5;
    localparam logic [SEL_W-1:0] OP_NOR = 4'd6;
    localparam logic [SEL_W-1:0] OP_SLL = 4'd7;
    localparam logic [SEL_W-1:0] OP_SRL = 4'd8;

    typedef struct packed {
        logic [REG_AW-1:0]  rd;
        logic               reg_write;
        logic [SEL_W-1:0]   op_sel;
        logic [SHAMT_W-1:0] shamt;
    } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode/EX/WB/ALU-facing bus of the ALU issue stage; slave is the stage, master is its environment.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [REG_AW-1:0]   in_rs;
    logic [REG_AW-1:0]   in_rt;
    logic [DATA_W-1:0]   in_rs_data;
    logic [DATA_W-1:0]   in_rt_data;
    logic [DATA_W-1:0]   in_imm;
    logic                in_alu_src;
    logic [SEL_W-1:0]    in_op_sel;
    logic [SHAMT_W-1:0]  in_shamt;
    logic [REG_AW-1:0]   in_rd;
    logic                in_reg_write;
    logic                ex_wr_en;
    logic [REG_AW-1:0]   ex_wr_rd;
    logic [DATA_W-1:0]   ex_wr_data;
    logic                ex_wr_pending;
    logic                wb_wr_en;
    logic [REG_AW-1:0]   wb_wr_rd;
    logic [DATA_W-1:0]   wb_wr_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   operand1;
    logic [DATA_W-1:0]   operand2;
    logic [SEL_W-1:0]    op_sel;
    logic [SHAMT_W-1:0]  shamt;
    logic [REG_AW-1:0]   out_rd;
    logic                out_reg_write;
    logic                hazard_stall;

    modport slave (
        input  in_valid, in_rs, in_rt, in_rs_data, in_rt_data, in_imm, in_alu_src,
               in_op_sel, in_shamt, in_rd, in_reg_write,
               ex_wr_en, ex_wr_rd, ex_wr_data, ex_wr_pending,
               wb_wr_en, wb_wr_rd, wb_wr_data, flush, out_ready,
        output in_ready, out_valid, operand1, operand2, op_sel, shamt,
               out_rd, out_reg_write, hazard_stall
    );

    modport master (
        output in_valid, in_rs, in_rt, in_rs_data, in_rt_data, in_imm, in_alu_src,
               in_op_sel, in_shamt, in_rd, in_reg_write,
               ex_wr_en, ex_wr_rd, ex_wr_data, ex_wr_pending,
               wb_wr_en, wb_wr_rd, wb_wr_data, flush, out_ready,
        input  in_ready, out_valid, operand1, operand2, op_sel, shamt,
               out_rd, out_reg_write, hazard_stall
    );

endinterface

// File: rtl/alu_fwd_mux.sv
// One source operand's writer match, EX > WB > register-file select and hazard flag.
// Forwarding is present only when ALU_ISSUE_FWD_EN is defined; otherwise any writer match stalls.
module alu_fwd_mux
    import alu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ex_pending,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] value,
    output logic              hazard
);

    logic src_zero;
    logic ex_match;
    logic wb_match;

    // r0 is hardwired to zero, so it never matches a writer and never reads anything but 0
    assign src_zero = (src == '0);
    assign ex_match = ex_en && (ex_rd == src) && !src_zero;
    assign wb_match = wb_en && (wb_rd == src) && !src_zero;

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        hazard = used && ex_match && ex_pending;
        value  = rf_data;
        if (src_zero) begin
            value = '0;
        end else if (ex_match) begin
            value = ex_data;
        end else if (wb_match) begin
            value = wb_data;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_data, wb_data, ex_pending};

    always_comb begin
        hazard = used && (ex_match || wb_match);
        value  = src_zero ? '0 : rf_data;
    end
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Decode->execute register driving the ALU ports, with RAW hazard resolution and valid/ready handshakes.
// Define ALU_ISSUE_FWD_EN to enable EX/WB forwarding; without it every used-source writer match stalls.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus
);

    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;
    logic              rs_hazard;
    logic              rt_hazard;
    logic              hazard;
    logic              in_ready;
    logic              accept;

    logic              valid_q;
    logic [DATA_W-1:0] operand1_q;
    logic [DATA_W-1:0] operand2_q;
    issue_t            issue_q;

    alu_fwd_mux u_fwd_rs (
        .src        (bus.in_rs),
        .used       (1'b1),
        .rf_data    (bus.in_rs_data),
        .ex_en      (bus.ex_wr_en),
        .ex_rd      (bus.ex_wr_rd),
        .ex_data    (bus.ex_wr_data),
        .ex_pending (bus.ex_wr_pending),
        .wb_en      (bus.wb_wr_en),
        .wb_rd      (bus.wb_wr_rd),
        .wb_data    (bus.wb_wr_data),
        .value      (rs_value),
        .hazard     (rs_hazard)
    );

    // rt is only a real source when operand2 comes from the register file
    alu_fwd_mux u_fwd_rt (
        .src        (bus.in_rt),
        .used       (!bus.in_alu_src),
        .rf_data    (bus.in_rt_data),
        .ex_en      (bus.ex_wr_en),
        .ex_rd      (bus.ex_wr_rd),
        .ex_data    (bus.ex_wr_data),
        .ex_pending (bus.ex_wr_pending),
        .wb_en      (bus.wb_wr_en),
        .wb_rd      (bus.wb_wr_rd),
        .wb_data    (bus.wb_wr_data),
        .value      (rt_value),
        .hazard     (rt_hazard)
    );

    assign hazard   = bus.in_valid && (rs_hazard || rt_hazard);
    assign in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    // Flush beats capture and hold; data fields keep their last value whenever the slot empties
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            operand1_q <= '0;
            operand2_q <= '0;
            issue_q    <= '0;
        end else if (bus.flush) begin
            valid_q           <= 1'b0;
            issue_q.reg_write <= 1'b0;
        end else if (accept) begin
            valid_q           <= 1'b1;
            operand1_q        <= rs_value;
            operand2_q        <= bus.in_alu_src ? bus.in_imm : rt_value;
            issue_q.rd        <= bus.in_rd;
            issue_q.reg_write <= bus.in_reg_write;
            issue_q.op_sel    <= bus.in_op_sel;
            issue_q.shamt     <= bus.in_shamt;
        end else if (bus.out_ready) begin
            valid_q           <= 1'b0;
            issue_q.reg_write <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.hazard_stall  = hazard;
    assign bus.out_valid     = valid_q;
    assign bus.operand1      = operand1_q;
    assign bus.operand2      = operand2_q;
    assign bus.op_sel        = issue_q.op_sel;
    assign bus.shamt         = issue_q.shamt;
    assign bus.out_rd        = issue_q.rd;
    assign bus.out_reg_write = issue_q.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [4:0]  in_rs;
        logic [4:0]  in_rt;
        logic [31:0] in_rs_data;
        logic [31:0] in_rt_data;
        logic [31:0] in_imm;
        logic        in_alu_src;
        logic [3:0]  in_op_sel;
        logic [4:0]  in_shamt;
        logic [4:0]  in_rd;
        logic        in_reg_write;
        logic        ex_wr_en;
        logic [4:0]  ex_wr_rd;
        logic [31:0] ex_wr_data;
        logic        ex_wr_pending;
        logic        wb_wr_en;
        logic [4:0]  wb_wr_rd;
        logic [31:0] wb_wr_data;
        logic        flush;
        logic        out_ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the ALU ports must hold, updated once per rising edge
    logic        m_init  = 1'b0;
    logic        m_valid;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [3:0]  m_opsel;
    logic [4:0]  m_shamt;
    logic [4:0]  m_rd;
    logic        m_rw;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic void resolveSrc(input logic [4:0] src, input logic [31:0] rf,
                                       output logic [31:0] val, output logic stall);
        logic ex_hit;
        logic wb_hit;
        ex_hit = bus.ex_wr_en && src != 5'd0 && bus.ex_wr_rd == src;
        wb_hit = bus.wb_wr_en && src != 5'd0 && bus.wb_wr_rd == src;
        val    = (src == 5'd0) ? 32'd0 : rf;
`ifdef ALU_ISSUE_FWD_EN
        stall = ex_hit && bus.ex_wr_pending;
        if (ex_hit) val = bus.ex_wr_data;
        else if (wb_hit) val = bus.wb_wr_data;
`else
        stall = ex_hit || wb_hit;
`endif
    endfunction

    function automatic void modelComb(output logic haz, output logic rdy,
                                      output logic [31:0] op1, output logic [31:0] op2);
        logic [31:0] v_rs;
        logic [31:0] v_rt;
        logic        s_rs;
        logic        s_rt;
        resolveSrc(bus.in_rs, bus.in_rs_data, v_rs, s_rs);
        resolveSrc(bus.in_rt, bus.in_rt_data, v_rt, s_rt);
        haz = bus.in_valid && (s_rs || (!bus.in_alu_src && s_rt));
        rdy = (!m_valid || bus.out_ready) && !haz && !bus.flush;
        op1 = v_rs;
        op2 = bus.in_alu_src ? bus.in_imm : v_rt;
    endfunction

    logic        p_haz;
    logic        p_rdy;
    logic [31:0] p_op1;
    logic [31:0] p_op2;

    always @(posedge clk) begin
        modelComb(p_haz, p_rdy, p_op1, p_op2);
        if (rst) begin
            m_valid = 1'b0; m_op1 = 0; m_op2 = 0; m_opsel = 0; m_shamt = 0; m_rd = 0; m_rw = 1'b0;
        end else if (bus.flush) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end else if (bus.in_valid && p_rdy) begin
            m_valid = 1'b1; m_op1 = p_op1; m_op2 = p_op2; m_opsel = bus.in_op_sel;
            m_shamt = bus.in_shamt; m_rd = bus.in_rd; m_rw = bus.in_reg_write;
        end else if (bus.out_ready) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end
        m_init = 1'b1;
    end

    logic        c_haz;
    logic        c_rdy;
    logic [31:0] c_op1;
    logic [31:0] c_op2;

    always @(negedge clk) begin
        if (m_init) begin
            modelComb(c_haz, c_rdy, c_op1, c_op2);
            checkOutput("model.in_ready", 32'(bus.in_ready), 32'(c_rdy));
            checkOutput("model.hazard_stall", 32'(bus.hazard_stall), 32'(c_haz));
            checkOutput("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
            checkOutput("model.operand1", bus.operand1, m_op1);
            checkOutput("model.operand2", bus.operand2, m_op2);
            checkOutput("model.op_sel", 32'(bus.op_sel), 32'(m_opsel));
            checkOutput("model.shamt", 32'(bus.shamt), 32'(m_shamt));
            checkOutput("model.out_rd", 32'(bus.out_rd), 32'(m_rd));
            checkOutput("model.out_reg_write", 32'(bus.out_reg_write), 32'(m_rw));
        end
    end

    task automatic driveInputs(input stim_t s);
        rst               = s.rst;
        bus.in_valid      = s.in_valid;
        bus.in_rs         = s.in_rs;
        bus.in_rt         = s.in_rt;
        bus.in_rs_data    = s.in_rs_data;
        bus.in_rt_data    = s.in_rt_data;
        bus.in_imm        = s.in_imm;
        bus.in_alu_src    = s.in_alu_src;
        bus.in_op_sel     = s.in_op_sel;
        bus.in_shamt      = s.in_shamt;
        bus.in_rd         = s.in_rd;
        bus.in_reg_write  = s.in_reg_write;
        bus.ex_wr_en      = s.ex_wr_en;
        bus.ex_wr_rd      = s.ex_wr_rd;
        bus.ex_wr_data    = s.ex_wr_data;
        bus.ex_wr_pending = s.ex_wr_pending;
        bus.wb_wr_en      = s.wb_wr_en;
        bus.wb_wr_rd      = s.wb_wr_rd;
        bus.wb_wr_data    = s.wb_wr_data;
        bus.flush         = s.flush;
        bus.out_ready     = s.out_ready;
    endtask

    // Inputs change just after a rising edge and stay put until the next one
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #2;
        driveInputs(s);
    endtask

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{rst: 1'b0, in_valid: 1'b0, in_rs: 5'd0, in_rt: 5'd0, in_rs_data: 32'd0,
              in_rt_data: 32'd0, in_imm: 32'd0, in_alu_src: 1'b0, in_op_sel: 4'd0,
              in_shamt: 5'd0, in_rd: 5'd0, in_reg_write: 1'b0, ex_wr_en: 1'b0,
              ex_wr_rd: 5'd0, ex_wr_data: 32'd0, ex_wr_pending: 1'b0, wb_wr_en: 1'b0,
              wb_wr_rd: 5'd0, wb_wr_data: 32'd0, flush: 1'b0, out_ready: 1'b1};
        return s;
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s = idleStim();
        s.rst           = ($urandom % 60) == 0;
        s.in_valid      = ($urandom % 4) != 0;
        s.in_rs         = 5'($urandom % 4);
        s.in_rt         = 5'($urandom % 4);
        s.in_rs_data    = $urandom;
        s.in_rt_data    = $urandom;
        s.in_imm        = $urandom;
        s.in_alu_src    = 1'($urandom % 2);
        s.in_op_sel     = 4'($urandom % 9);
        s.in_shamt      = 5'($urandom % 32);
        s.in_rd         = 5'($urandom % 4);
        s.in_reg_write  = 1'($urandom % 2);
        s.ex_wr_en      = 1'($urandom % 2);
        s.ex_wr_rd      = 5'($urandom % 4);
        s.ex_wr_data    = $urandom;
        s.ex_wr_pending = s.ex_wr_en && (($urandom % 3) == 0);
        s.wb_wr_en      = 1'($urandom % 2);
        s.wb_wr_rd      = 5'($urandom % 4);
        s.wb_wr_data    = $urandom;
        s.flush         = ($urandom % 16) == 0;
        s.out_ready     = ($urandom % 4) != 0;
        return s;
    endfunction

    initial begin
        stim_t s;
        s = idleStim();
        s.rst = 1'b1;
        driveInputs(s);

        // Reset held for two edges
        applyStimulus(s);
        applyStimulus(s);
        waitNeg();
        checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset.op_sel", 32'(bus.op_sel), 32'd0);
        checkOutput("reset.operand1", bus.operand1, 32'd0);
        checkOutput("reset.operand2", bus.operand2, 32'd0);
        s.rst = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // ADD r3 = r1 + r2 with no writers in flight
        s = idleStim();
        s.in_valid = 1'b1; s.in_rs = 5'd1; s.in_rt = 5'd2; s.in_rs_data = 32'd5; s.in_rt_data = 32'd7;
        s.in_op_sel = OP_ADD; s.in_rd = 5'd3; s.in_reg_write = 1'b1;
        applyStimulus(s);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("add.operand1", bus.operand1, 32'd5);
        checkOutput("add.operand2", bus.operand2, 32'd7);
        checkOutput("add.op_sel", 32'(bus.op_sel), 32'd0);
        checkOutput("add.out_valid", 32'(bus.out_valid), 32'd1);

        // EX and WB both write r1
        s = idleStim();
        s.in_valid = 1'b1; s.in_rs = 5'd1; s.in_rs_data = 32'd9; s.in_op_sel = OP_SUB; s.in_rd = 5'd4;
        s.ex_wr_en = 1'b1; s.ex_wr_rd = 5'd1; s.ex_wr_data = 32'd100;
        s.wb_wr_en = 1'b1; s.wb_wr_rd = 5'd1; s.wb_wr_data = 32'd50;
        applyStimulus(s);
        waitNeg();
`ifdef ALU_ISSUE_FWD_EN
        checkOutput("fwd.no_stall", 32'(bus.hazard_stall), 32'd0);
        s.ex_wr_en = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("fwd.ex_priority", bus.operand1, 32'd100);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("fwd.wb_value", bus.operand1, 32'd50);
`else
        checkOutput("nofwd.stall_ex_wb", 32'(bus.hazard_stall), 32'd1);
        s.ex_wr_en = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("nofwd.stall_wb", 32'(bus.hazard_stall), 32'd1);
        s.wb_wr_en = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("nofwd.released", 32'(bus.hazard_stall), 32'd0);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("nofwd.rf_value", bus.operand1, 32'd9);
`endif

        // Pending load in EX writing r2 while rt=r2 is used
        s = idleStim();
        s.in_valid = 1'b1; s.in_rt = 5'd2; s.in_rt_data = 32'd11; s.in_op_sel = OP_OR;
        s.ex_wr_en = 1'b1; s.ex_wr_rd = 5'd2; s.ex_wr_data = 32'd77; s.ex_wr_pending = 1'b1;
        applyStimulus(s);
        waitNeg();
        checkOutput("load.stall", 32'(bus.in_ready), 32'd0);
        s.ex_wr_pending = 1'b0;
        applyStimulus(s);
        waitNeg();
`ifdef ALU_ISSUE_FWD_EN
        checkOutput("load.accept", 32'(bus.in_ready), 32'd1);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("load.forwarded", bus.operand2, 32'd77);
`else
        checkOutput("load.still_stalled", 32'(bus.in_ready), 32'd0);
        s.ex_wr_en = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("load.accept", 32'(bus.in_ready), 32'd1);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("load.rf_value", bus.operand2, 32'd11);
`endif

        // Same pending load, but operand2 is the immediate so rt is unused
        s = idleStim();
        s.in_valid = 1'b1; s.in_rt = 5'd2; s.in_alu_src = 1'b1; s.in_imm = 32'h1234;
        s.ex_wr_en = 1'b1; s.ex_wr_rd = 5'd2; s.ex_wr_data = 32'd77; s.ex_wr_pending = 1'b1;
        applyStimulus(s);
        waitNeg();
        checkOutput("imm.no_stall", 32'(bus.in_ready), 32'd1);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("imm.operand2", bus.operand2, 32'h1234);

        // Downstream back-pressure; the held instruction reads r0 despite an r0 writer
        s = idleStim();
        s.out_ready = 1'b0; s.in_valid = 1'b1; s.in_rs = 5'd0; s.in_rs_data = 32'd99;
        s.in_op_sel = OP_XOR; s.in_shamt = 5'd3; s.in_rd = 5'd6; s.in_reg_write = 1'b1;
        s.ex_wr_en = 1'b1; s.ex_wr_rd = 5'd0; s.ex_wr_data = 32'd55;
        applyStimulus(s);
        s.in_rs = 5'd1; s.in_rs_data = 32'd42; s.in_op_sel = OP_SLL; s.ex_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            waitNeg();
            checkOutput("hold.in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold.r0_operand1", bus.operand1, 32'd0);
            checkOutput("hold.op_sel", 32'(bus.op_sel), 32'(OP_XOR));
        end
        s.out_ready = 1'b1;
        applyStimulus(s);
        waitNeg();
        checkOutput("hold.release_ready", 32'(bus.in_ready), 32'd1);
        s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("hold.next_operand1", bus.operand1, 32'd42);
        checkOutput("hold.next_op_sel", 32'(bus.op_sel), 32'(OP_SLL));

        // Flush while holding a valid instruction with another one presented
        s = idleStim();
        s.in_valid = 1'b1; s.in_rs = 5'd3; s.in_rs_data = 32'hAAAA; s.in_rd = 5'd7; s.in_reg_write = 1'b1;
        applyStimulus(s);
        s.in_rs_data = 32'hBBBB; s.flush = 1'b1;
        applyStimulus(s);
        waitNeg();
        checkOutput("flush.before_valid", 32'(bus.out_valid), 32'd1);
        s.flush = 1'b0; s.in_valid = 1'b0;
        applyStimulus(s);
        waitNeg();
        checkOutput("flush.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush.out_reg_write", 32'(bus.out_reg_write), 32'd0);
        checkOutput("flush.not_captured", bus.operand1, 32'hAAAA);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(randomStim());
        end
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        waitNeg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
